ahb_sram_slave_p: RTL and testbench
===================================

Name: ahb_sram_slave_p

Overview:
- Parametrised AHB-Lite slave SRAM, next generation of the single-port RAM slave.
- Adds configurable depth, byte/halfword writes via byte lanes, and a programmable number of wait states.
- Adds an ERROR response for illegal accesses, plus read-after-write forwarding.
- Sits on the Cortex-M0 AHB matrix as the data/instruction RAM slave.

Parameters:
- MEM_AW, 12, word-address width; depth = 2**MEM_AW 32-bit words (byte range 4*2**MEM_AW).
- WAIT_STATES, 0, extra data-phase cycles (HREADYOUT low) per OKAY transfer; legal range 0..3.
- INIT_ZERO, 1, 1: the model clears memory at time zero (simulation only); 0: contents X.

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  32  byte address; bits [MEM_AW+1:0] are used, upper bits are ignored.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  000 byte, 001 halfword, 010 word; others illegal.
- HBURST  in  3  ignored (bursts are handled beat by beat).
- HPROT  in  4  ignored.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (end of previous data phase).
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset, asynchronous: HRDATA=0, HREADYOUT=1, HRESP=00, FSM=IDLE, wait counter=0, pending-write valid=0. Memory contents are not affected.
- Transfer accept: a transfer is accepted when HSEL & HREADY & HTRANS[1] at the rising edge.
  - Latch: word address, HWRITE, and byte-lane mask.
  - Lane mask: byte = 1<<HADDR[1:0]; halfword = 0011 or 1100 by HADDR[1]; word = 1111.
- Illegal accesses:
  - HSIZE>2, halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Illegal accesses go to ERR1, never touch memory, and ignore WAIT_STATES.
- IDLE/BUSY or unselected: no memory access; slave stays in IDLE with HREADYOUT=1 and HRESP=00 (zero-wait OKAY).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE→WAIT on a legal accept when WAIT_STATES>0; wait counter loads WAIT_STATES.
  - IDLE→DATA on a legal accept when WAIT_STATES=0.
  - WAIT: HREADYOUT=0, HRESP=00; the counter decrements each cycle; →DATA when the counter reaches 1.
  - DATA: HREADYOUT=1, HRESP=00, transfer completes. A new accept in the same cycle re-enters WAIT/DATA/ERR1, so back-to-back transfers are supported with no bubble when WAIT_STATES=0.
  - ERR1: HREADYOUT=0, HRESP=01. Next state is always ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Next state is IDLE, or WAIT/DATA/ERR1 if a new accept occurs this cycle. A transfer issued during ERR2 is accepted normally.
- Write:
  - On the completing (DATA) edge, HWDATA lanes selected by the mask are written to the memory word.
  - Unselected lanes keep their value.
- Read:
  - Memory is read at the edge that enters DATA.
  - HRDATA holds the full 32-bit word throughout the DATA cycle; byte/halfword selection is the master's job.
  - HRDATA holds its last value in all other states.
- Read-after-write hazard:
  - A read entering DATA while a write to the same word completes at that edge returns the merged word: new lanes come from HWDATA, the rest from memory.
  - A different word reads memory directly.
- Address wrap: the address is truncated to MEM_AW word bits, so addresses beyond the range alias modulo the depth. No ERROR is raised for aliasing.
- HRESET asserted mid-transfer: the FSM aborts to IDLE immediately (asynchronous). A write that has not reached its DATA edge is not performed.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x10, then read @0x10 → HREADYOUT stays 1, HRDATA=0xDEADBEEF in the read data phase, HRESP=00.
- Byte write 0xAA @0x13 over word 0x11223344 → read @0x10 returns 0xAA223344; halfword write 0x5566 @0x10 then returns 0xAA225566.
- WAIT_STATES=2: single read → HREADYOUT low exactly 2 cycles, then high with data; back-to-back write+read to the same word → read returns the written value (forwarding).
- HSIZE=010 @0x02 → HRESP=01 with HREADYOUT 0 then 1 (two cycles), memory unchanged; the next legal transfer completes OKAY.
- MEM_AW=4: write 0x1 @0x00 then read @0x40 → returns 0x1 (aliasing); assert HRESET during WAIT → HREADYOUT=1, HRESP=00, HRDATA=0 immediately, and the write is not committed.

Source files
------------

// File: rtl/ahb_sram_slave_p.sv
// ahb_sram_slave_p: AHB-Lite SRAM slave with byte lanes, wait states, ERROR response and RAW forwarding
module ahb_sram_slave_p #(
  parameter int MEM_AW      = 12,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_ERR1 = 3'd3;
  localparam logic [2:0] S_ERR2 = 3'd4;
  logic [2:0]        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [3:0]        mask_q, mask_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [2**MEM_AW];
  logic              accept, illegal, do_wr, rd_wr;
  logic [3:0]        lanes;
  logic [MEM_AW-1:0] haddr_w, raddr;
  logic [31:0]       rword;
  logic              unused_bits;
  assign unused_bits = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:MEM_AW+2], INIT_ZERO != 0};
  assign HREADYOUT = !(state_q == S_WAIT || state_q == S_ERR1);
  assign HRESP     = {1'b0, state_q == S_ERR1 || state_q == S_ERR2};
  assign HRDATA    = rdata_q;
  // decode the address phase: accept, legality and byte-lane mask
  always_comb begin
    haddr_w = HADDR[MEM_AW+1:2];
    accept  = HSEL & HREADY & HTRANS[1] & (state_q == S_IDLE || state_q == S_DATA || state_q == S_ERR2);
    illegal = (HSIZE > 3'd2) | (HSIZE == 3'd1 & HADDR[0]) | (HSIZE == 3'd2 & |HADDR[1:0]);
    lanes   = HSIZE == 3'd0 ? 4'b0001 << HADDR[1:0] : HSIZE == 3'd1 ? (HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    do_wr   = state_q == S_DATA & wr_q;
  end
  // next-state logic; accepts only happen in states that drive HREADYOUT high
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    if (state_q == S_WAIT) begin
      cnt_d   = cnt_q - 2'd1;
      state_d = cnt_q == 2'd1 ? S_DATA : S_WAIT;
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else begin
      state_d = !accept ? S_IDLE : illegal ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_DATA;
      if (accept) begin
        addr_d = haddr_w;
        wr_d   = HWRITE & !illegal;
        mask_d = lanes;
        cnt_d  = 2'(WAIT_STATES);
      end
    end
  end
  // read on the edge entering DATA, merging lanes of a write that commits on the same edge
  always_comb begin
    raddr = state_q == S_WAIT ? addr_q : haddr_w;
    rd_wr = state_q == S_WAIT ? wr_q : HWRITE;
    rword = mem_q[raddr];
    for (int i = 0; i < 4; i++)
      if (do_wr && mask_q[i] && addr_q == raddr) rword[8*i +: 8] = HWDATA[8*i +: 8];
    rdata_d = (state_d == S_DATA && !rd_wr) ? rword : rdata_q;
  end
  // control and read-data registers, aborted asynchronously by reset
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end
  // memory array: selected lanes are written on the edge that completes a write data phase
  always_ff @(posedge HCLK) begin
    for (int i = 0; i < 4; i++)
      if (do_wr && mask_q[i]) mem_q[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
  end
endmodule

// File: tb/tb_ahb_sram_slave_p.sv
// tb_ahb_sram_slave_p: directed vectors, corner sequences and random transfers against a word-array model
module tb_ahb_sram_slave_p;
  typedef struct {
    int          k;
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          chk_rd;
    logic [1:0]  exp_resp;
    int          exp_low;
  } vec_t;

  logic        clk = 0;
  logic        rst = 1;
  logic [2:0]  sel = '0;
  logic [31:0] haddr = '0, hwdata = '0;
  logic [1:0]  htrans = '0;
  logic        hwrite = 0;
  logic [2:0]  hsize = '0;
  logic [31:0] rdata [3];
  logic        rdy [3];
  logic [1:0]  resp [3];
  int          ws [3] = '{0, 2, 1};
  int          checks = 0, errors = 0;
  vec_t        tbl [$];
  logic [31:0] mdl [3][16];
  logic [31:0] rd;
  logic [1:0]  rf, rl;
  int          low;

  always #5 clk = ~clk;

  ahb_sram_slave_p #(.MEM_AW(12), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(rdy[0]),
    .HWDATA(hwdata), .HRDATA(rdata[0]), .HREADYOUT(rdy[0]), .HRESP(resp[0]));
  ahb_sram_slave_p #(.MEM_AW(12), .WAIT_STATES(2)) u1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(rdy[1]),
    .HWDATA(hwdata), .HRDATA(rdata[1]), .HREADYOUT(rdy[1]), .HRESP(resp[1]));
  ahb_sram_slave_p #(.MEM_AW(4), .WAIT_STATES(1)) u2 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[2]), .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite),
    .HSIZE(hsize), .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0), .HREADY(rdy[2]),
    .HWDATA(hwdata), .HRDATA(rdata[2]), .HREADYOUT(rdy[2]), .HRESP(resp[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] wd, input logic [31:0] er, input bit cr,
                     input logic [1:0] eresp, input int elow);
    vec_t v;
    v.k = k; v.wr = wr; v.addr = a; v.sz = sz; v.wd = wd;
    v.exp_rd = er; v.chk_rd = cr; v.exp_resp = eresp; v.exp_low = elow;
    tbl.push_back(v);
  endtask

  // single non-pipelined transfer; starts and ends 1 time unit after a rising edge with the bus idle
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] o_rd, output logic [1:0] o_rf,
                      output logic [1:0] o_rl, output int o_low);
    sel = '0; sel[k] = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    @(posedge clk); #1;
    sel = '0; htrans = 2'b00; hwdata = wr ? wd : $urandom;
    o_rf = resp[k]; o_low = 0;
    while (!rdy[k] && o_low < 8) begin
      o_low++;
      @(posedge clk); #1;
    end
    o_rd = rdata[k]; o_rl = resp[k];
    @(posedge clk); #1;
  endtask

  // write immediately followed by a read issued in the write's data phase
  task automatic b2b(input int k, input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                     input logic [31:0] ra, input logic [31:0] exp);
    int n;
    sel = '0; sel[k] = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = wa; hsize = wsz;
    @(posedge clk); #1;
    hwdata = wd; htrans = 2'b00; n = 0;
    while (!rdy[k] && n < 8) begin n++; @(posedge clk); #1; end
    chk($sformatf("b2b%0d write low", k), n, ws[k]);
    htrans = 2'b10; hwrite = 1'b0; haddr = ra; hsize = 3'd2;
    @(posedge clk); #1;
    htrans = 2'b00; sel = '0; n = 0;
    while (!rdy[k] && n < 8) begin n++; @(posedge clk); #1; end
    chk($sformatf("b2b%0d read low", k), n, ws[k]);
    chk($sformatf("b2b%0d read data", k), rdata[k], exp);
    chk($sformatf("b2b%0d read resp", k), {30'd0, resp[k]}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before timeout");
    $fatal(1);
  end

  initial begin
    add(0, 1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 0, 2'd0, 0);
    add(0, 0, 32'h10, 3'd2, 0, 32'hDEADBEEF, 1, 2'd0, 0);
    add(0, 1, 32'h10, 3'd2, 32'h11223344, 0, 0, 2'd0, 0);
    add(0, 1, 32'h13, 3'd0, 32'hAA000000, 0, 0, 2'd0, 0);
    add(0, 0, 32'h10, 3'd2, 0, 32'hAA223344, 1, 2'd0, 0);
    add(0, 1, 32'h10, 3'd1, 32'h00005566, 0, 0, 2'd0, 0);
    add(0, 0, 32'h10, 3'd2, 0, 32'hAA225566, 1, 2'd0, 0);
    add(0, 1, 32'h00, 3'd2, 32'h01020304, 0, 0, 2'd0, 0);
    add(0, 1, 32'h02, 3'd2, 32'hFFFFFFFF, 0, 0, 2'd1, 1);
    add(0, 0, 32'h00, 3'd2, 0, 32'h01020304, 1, 2'd0, 0);
    add(0, 1, 32'h10, 3'd3, 32'hFFFFFFFF, 0, 0, 2'd1, 1);
    add(0, 1, 32'h11, 3'd1, 32'hFFFFFFFF, 0, 0, 2'd1, 1);
    add(0, 0, 32'h10, 3'd2, 0, 32'hAA225566, 1, 2'd0, 0);
    add(0, 1, 32'h30, 3'd2, 32'hCAFEF00D, 0, 0, 2'd0, 0);
    add(1, 1, 32'h20, 3'd2, 32'h12345678, 0, 0, 2'd0, 2);
    add(1, 0, 32'h20, 3'd2, 0, 32'h12345678, 1, 2'd0, 2);
    add(1, 1, 32'h44, 3'd2, 32'hA5A5A5A5, 0, 0, 2'd0, 2);
    add(1, 0, 32'h21, 3'd1, 0, 0, 0, 2'd1, 1);
    add(2, 1, 32'h00, 3'd2, 32'h00000001, 0, 0, 2'd0, 1);
    add(2, 0, 32'h40, 3'd2, 0, 32'h00000001, 1, 2'd0, 1);
    add(2, 1, 32'h08, 3'd2, 32'h0BADF00D, 0, 0, 2'd0, 1);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset rdy%0d", k), {31'd0, rdy[k]}, 1);
      chk($sformatf("reset resp%0d", k), {30'd0, resp[k]}, 0);
      chk($sformatf("reset rdata%0d", k), rdata[k], 0);
    end

    foreach (tbl[i]) begin
      xfer(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].sz, tbl[i].wd, rd, rf, rl, low);
      chk($sformatf("vec%0d first resp", i), {30'd0, rf}, {30'd0, tbl[i].exp_resp});
      chk($sformatf("vec%0d last resp", i), {30'd0, rl}, {30'd0, tbl[i].exp_resp});
      chk($sformatf("vec%0d wait cycles", i), low, tbl[i].exp_low);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rd);
    end

    b2b(0, 32'h31, 3'd0, 32'h99887766, 32'h30, 32'hCAFE770D);
    b2b(1, 32'h46, 3'd1, 32'hBEEF1234, 32'h44, 32'hBEEFA5A5);

    sel = 3'b100; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h08; hsize = 3'd2;
    @(posedge clk); #1;
    sel = '0; htrans = 2'b00; hwdata = 32'hFFFFFFFF;
    chk("abort in wait rdy", {31'd0, rdy[2]}, 0);
    rst = 1; #1;
    chk("abort rdy", {31'd0, rdy[2]}, 1);
    chk("abort resp", {30'd0, resp[2]}, 0);
    chk("abort rdata", rdata[2], 0);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    xfer(2, 0, 32'h08, 3'd2, 0, rd, rf, rl, low);
    chk("abort write dropped", rd, 32'h0BADF00D);
    chk("abort read low", low, 1);

    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 16; w++) begin
        mdl[k][w] = $urandom;
        xfer(k, 1, 32'(w * 4), 3'd2, mdl[k][w], rd, rf, rl, low);
      end

    for (int it = 0; it < 300; it++) begin
      int k, w, off;
      logic [2:0] sz;
      logic [31:0] a, v;
      bit wr, legal;
      k = $urandom_range(0, 2);
      w = $urandom_range(0, 15);
      off = $urandom_range(0, 3);
      sz = 3'($urandom_range(0, 3));
      if (sz == 3'd3) sz = 3'($urandom_range(3, 7));
      a = ($urandom & (k == 2 ? 32'hFFFF_FFC0 : 32'hFFFF_C000)) | 32'(w * 4 + off);
      wr = 1'($urandom_range(0, 1));
      v = $urandom;
      legal = sz == 3'd0 || (sz == 3'd1 && off % 2 == 0) || (sz == 3'd2 && off == 0);
      xfer(k, wr, a, sz, v, rd, rf, rl, low);
      chk($sformatf("rnd%0d resp", it), {30'd0, rl}, legal ? 0 : 1);
      chk($sformatf("rnd%0d wait cycles", it), low, legal ? ws[k] : 1);
      if (legal && wr) begin
        for (int b = 0; b < 4; b++)
          if (sz == 3'd2 || (sz == 3'd1 && b / 2 == off / 2) || (sz == 3'd0 && b == off))
            mdl[k][w][8*b +: 8] = v[8*b +: 8];
      end else if (legal)
        chk($sformatf("rnd%0d rdata", it), rd, mdl[k][w]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
